// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the CPU/DMA data-memory arbiter.
// Bus widths, default burst/starvation limits and FSM state encodings live here.
package mem_arbiter_pkg;

    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 32;
    localparam int MAX_BURST_DEF    = 8;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [0:0] {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_e;

    // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the CPU MEM-stage port, the DMA port and the DataMem port of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding SoC / bench view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              cpu_ce;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_ce, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_ce, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_ce, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_ce, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port DataMem between the CPU MEM stage and a DMA engine.
// CPU path is purely combinational; DMA bursts are bounded and CPU starvation is bounded.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST    = MAX_BURST_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int BURST_W  = cnt_width(MAX_BURST);
    localparam int STARVE_W = cnt_width(STARVE_LIMIT - 1);
    localparam logic [BURST_W-1:0]  BURST_TOP  = BURST_W'(MAX_BURST);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIMIT - 1);

    state_e              state_q, state_d;
    logic [BURST_W-1:0]  burst_q, burst_d, burst_inc;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
    logic                dma_rvalid_q, dma_rvalid_d;
    logic                dma_owner;

    // Reset gates ownership so every strobe derived from it is forced low while rst=0.
    assign dma_owner = rst && (state_q == S_DMA) && bus.dma_req;

    always_comb begin
        bus.mem_ce    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        if (dma_owner) begin
            bus.mem_ce    = 1'b1;
            bus.mem_we    = bus.dma_we;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end else if (rst) begin
            bus.mem_ce = bus.cpu_ce;
            bus.mem_we = bus.cpu_ce && bus.cpu_we;
        end
    end

    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.cpu_stall  = dma_owner && bus.cpu_ce;
    assign bus.dma_gnt    = dma_owner;
    assign bus.dma_rdata  = dma_rdata_q;
    assign bus.dma_rvalid = dma_rvalid_q;

    assign dma_rvalid_d = dma_owner && !bus.dma_we;
    assign dma_rdata_d  = dma_rvalid_d ? bus.mem_rdata : dma_rdata_q;

    // The burst limit is judged on the count including this cycle's grant, so the
    // MAX_BURST-th grant is the last one before a waiting CPU takes over.
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        starve_d  = starve_q;
        burst_inc = (burst_q == BURST_TOP) ? burst_q : burst_q + BURST_W'(1);
        case (state_q)
            S_CPU: begin
                if (!bus.dma_req) begin
                    starve_d = '0;
                end else if (!bus.cpu_ce || (starve_q == STARVE_TOP)) begin
                    state_d  = S_DMA;
                    starve_d = '0;
                    burst_d  = '0;
                end else begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            S_DMA: begin
                starve_d = '0;
                if (!bus.dma_req) begin
                    state_d = S_CPU;
                end else begin
                    burst_d = burst_inc;
                    if ((burst_inc == BURST_TOP) && bus.cpu_ce) begin
                        state_d = S_CPU;
                    end
                end
            end
            default: begin
                state_d  = S_CPU;
                starve_d = '0;
                burst_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_CPU;
            burst_q      <= '0;
            starve_q     <= '0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            starve_q     <= starve_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a per-cycle scoreboard driven by a
// transaction-level model of the arbitration rules, plus directed literal checks.
module tb_mem_arbiter;

    localparam int MAX_BURST    = 8;
    localparam int STARVE_LIMIT = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_BURST    (MAX_BURST),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side DataMem: combinational read, clocked write.
    logic [31:0] memArr [0:255] = '{default: 32'h0};
    assign bus.mem_rdata = memArr[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (bus.mem_ce && bus.mem_we) memArr[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic cCe, input logic cWe, input logic [31:0] cAddr,
                                 input logic [31:0] cWdata, input logic dReq, input logic dWe,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata);
        bus.cpu_ce    = cCe;
        bus.cpu_we    = cWe;
        bus.cpu_addr  = cAddr;
        bus.cpu_wdata = cWdata;
        bus.dma_req   = dReq;
        bus.dma_we    = dWe;
        bus.dma_addr  = dAddr;
        bus.dma_wdata = dWdata;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: who holds the memory slot, how many grants the
    // current burst has used, and how long the CPU has kept a pending DMA waiting.
    logic [31:0] refMem [0:255] = '{default: 32'h0};
    bit          modelDma    = 1'b0;
    int          burstGrants = 0;
    int          cpuWaits    = 0;
    logic        expRvalid   = 1'b0;
    logic [31:0] expRdata    = 32'h0;
    logic        dmaNow, eCe, eWe;
    logic [31:0] eAddr, eWdata;

    always @(negedge clk) begin
        dmaNow = rst && modelDma && bus.dma_req;
        eCe    = rst && (dmaNow || bus.cpu_ce);
        eWe    = rst && (dmaNow ? bus.dma_we : (bus.cpu_ce && bus.cpu_we));
        eAddr  = dmaNow ? bus.dma_addr : bus.cpu_addr;
        eWdata = dmaNow ? bus.dma_wdata : bus.cpu_wdata;

        checkOutput("sb_mem_ce", 64'(bus.mem_ce), 64'(eCe));
        checkOutput("sb_mem_we", 64'(bus.mem_we), 64'(eWe));
        checkOutput("sb_dma_gnt", 64'(bus.dma_gnt), 64'(dmaNow));
        checkOutput("sb_cpu_stall", 64'(bus.cpu_stall), 64'(dmaNow && bus.cpu_ce));
        if (eCe) checkOutput("sb_mem_addr", 64'(bus.mem_addr), 64'(eAddr));
        if (eWe) checkOutput("sb_mem_wdata", 64'(bus.mem_wdata), 64'(eWdata));
        if (rst && bus.cpu_ce && !bus.cpu_we && !dmaNow)
            checkOutput("sb_cpu_rdata", 64'(bus.cpu_rdata), 64'(refMem[bus.cpu_addr[7:0]]));
        checkOutput("sb_dma_rvalid", 64'(bus.dma_rvalid), 64'(expRvalid));
        checkOutput("sb_dma_rdata", 64'(bus.dma_rdata), 64'(expRdata));

        if (!rst) begin
            modelDma    = 1'b0;
            burstGrants = 0;
            cpuWaits    = 0;
            expRvalid   = 1'b0;
            expRdata    = 32'h0;
        end else begin
            expRvalid = dmaNow && !bus.dma_we;
            if (expRvalid) expRdata = refMem[bus.dma_addr[7:0]];
            if (eWe) refMem[eAddr[7:0]] = eWdata;
            if (modelDma) begin
                cpuWaits = 0;
                if (!bus.dma_req) begin
                    modelDma = 1'b0;
                end else begin
                    if (burstGrants < MAX_BURST) burstGrants++;
                    if (burstGrants == MAX_BURST && bus.cpu_ce) modelDma = 1'b0;
                end
            end else if (bus.dma_req) begin
                if (!bus.cpu_ce || cpuWaits == STARVE_LIMIT - 1) begin
                    modelDma    = 1'b1;
                    burstGrants = 0;
                    cpuWaits    = 0;
                end else begin
                    cpuWaits++;
                end
            end else begin
                cpuWaits = 0;
            end
        end
    end

    int          wordIdx;
    logic [63:0] gntVec, stallVec;

    initial begin
        // Reset with both masters requesting: all strobes must stay low.
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h10, 32'hEEEE_EEEE);
        @(negedge clk);
        checkOutput("reset_mem_ce", 64'(bus.mem_ce), 64'd0);
        checkOutput("reset_mem_we", 64'(bus.mem_we), 64'd0);
        checkOutput("reset_dma_gnt", 64'(bus.dma_gnt), 64'd0);
        checkOutput("reset_cpu_stall", 64'(bus.cpu_stall), 64'd0);
        checkOutput("reset_dma_rvalid", 64'(bus.dma_rvalid), 64'd0);
        checkOutput("reset_dma_rdata", 64'(bus.dma_rdata), 64'd0);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("idle_mem_ce", 64'(bus.mem_ce), 64'd0);
        nextCycle();

        // DMA write while CPU idle: granted on the second cycle, then CPU reads it back.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5);
        @(negedge clk);
        checkOutput("dma_wr_first_cycle_gnt", 64'(bus.dma_gnt), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("dma_wr_gnt", 64'(bus.dma_gnt), 64'd1);
        checkOutput("dma_wr_mem_we", 64'(bus.mem_we), 64'd1);
        checkOutput("dma_wr_mem_addr", 64'(bus.mem_addr), 64'h10);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("cpu_rd_0x10_data", 64'(bus.cpu_rdata), 64'hA5A5_A5A5);
        checkOutput("cpu_rd_0x10_stall", 64'(bus.cpu_stall), 64'd0);
        nextCycle();

        // CPU stores 0x12345678 at 0x20, DMA reads it back.
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        checkOutput("dma_rd_first_cycle_gnt", 64'(bus.dma_gnt), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("dma_rd_gnt", 64'(bus.dma_gnt), 64'd1);
        checkOutput("dma_rd_rvalid_same_cycle", 64'(bus.dma_rvalid), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("dma_rd_rvalid", 64'(bus.dma_rvalid), 64'd1);
        checkOutput("dma_rd_rdata", 64'(bus.dma_rdata), 64'h1234_5678);
        nextCycle();
        @(negedge clk);
        checkOutput("dma_rd_rvalid_drop", 64'(bus.dma_rvalid), 64'd0);
        checkOutput("dma_rd_rdata_hold", 64'(bus.dma_rdata), 64'h1234_5678);
        nextCycle();

        // 20-word DMA burst against a CPU that never lets go of cpu_ce:
        // 4 CPU cycles, 8 grants, 4 CPU, 8 grants, 4 CPU, 4 grants, then same-cycle handoff.
        wordIdx  = 0;
        gntVec   = '0;
        stallVec = '0;
        for (int cyc = 0; cyc < 33; cyc++) begin
            applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, wordIdx < 20, 1'b1,
                          32'h40 + 32'(wordIdx), 32'hD000_0000 + 32'(wordIdx));
            @(negedge clk);
            gntVec[cyc]   = bus.dma_gnt;
            stallVec[cyc] = bus.cpu_stall;
            if (cyc == 32) begin
                checkOutput("handoff_stall", 64'(bus.cpu_stall), 64'd0);
                checkOutput("handoff_mem_ce", 64'(bus.mem_ce), 64'd1);
                checkOutput("handoff_mem_addr", 64'(bus.mem_addr), 64'h10);
            end
            if (bus.dma_gnt === 1'b1) wordIdx++;
            nextCycle();
        end
        checkOutput("starve_gnt_pattern", gntVec, 64'h0_F0FF_0FF0);
        checkOutput("starve_stall_pattern", stallVec, 64'h0_F0FF_0FF0);
        checkOutput("starve_words_done", 64'(wordIdx), 64'd20);
        applyStimulus(1'b1, 1'b0, 32'h53, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("burst_last_word", 64'(bus.cpu_rdata), 64'hD000_0013);
        nextCycle();

        // CPU idle: burst counter saturates and DMA keeps every grant (10 back-to-back).
        wordIdx = 0;
        gntVec  = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, wordIdx < 10, 1'b1,
                          32'h60 + 32'(wordIdx), 32'hC000_0000 + 32'(wordIdx));
            @(negedge clk);
            gntVec[cyc] = bus.dma_gnt;
            if (bus.dma_gnt === 1'b1) wordIdx++;
            nextCycle();
        end
        checkOutput("saturate_gnt_pattern", gntVec, 64'h7FE);
        applyStimulus(1'b1, 1'b0, 32'h69, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("saturate_last_word", 64'(bus.cpu_rdata), 64'hC000_0009);
        nextCycle();

        // Reset arrives while burst word 3 is presented: that word must never land.
        wordIdx = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                          32'h80 + 32'(wordIdx), 32'hBB00_0000 + 32'(wordIdx));
            @(negedge clk);
            if (bus.dma_gnt === 1'b1) wordIdx++;
            nextCycle();
        end
        checkOutput("abort_words_before_reset", 64'(wordIdx), 64'd3);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h83, 32'hBB00_0003);
        @(negedge clk);
        checkOutput("abort_reset_gnt", 64'(bus.dma_gnt), 64'd0);
        checkOutput("abort_reset_mem_we", 64'(bus.mem_we), 64'd0);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h83, 32'h0, 1'b1, 1'b1, 32'h83, 32'hBB00_0003);
        @(negedge clk);
        checkOutput("abort_after_gnt", 64'(bus.dma_gnt), 64'd0);
        checkOutput("abort_after_stall", 64'(bus.cpu_stall), 64'd0);
        checkOutput("abort_word3_unwritten", 64'(bus.cpu_rdata), 64'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h82, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("abort_word2_written", 64'(bus.cpu_rdata), 64'hBB00_0002);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
